// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
`include "isa.svh"
package ifu_pkg;
  localparam int IFU_PC_W    = `RV_PC_SIZE;
  localparam int IFU_IR_W    = `RV_IR_SIZE;
  localparam int IFU_PC_STEP = 4;

  typedef struct packed {
    logic [IFU_PC_W-1:0] pc;
    logic [IFU_IR_W-1:0] ir;
  } ibuf_entry_t;
endpackage

// File: rtl/ifu_ibuf.sv
// Instruction buffer: synchronous FIFO of {pc, ir} with flush and concurrent push/pop.
module ifu_ibuf
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        push_i,
  input  ibuf_entry_t push_data_i,
  input  logic        pop_i,
  output ibuf_entry_t head_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  localparam logic [AW:0] PTR_ONE = 1;

  ibuf_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        full, do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/isa.svh
// ISA-wide widths shared by the fetch unit and its package.
`ifndef ISA_SVH
`define ISA_SVH
`define RV_PC_SIZE 32
`define RV_IR_SIZE 32
`endif

// File: rtl/ifu_pf.sv
// Prefetching fetch unit: keeps up to OUTSTD bus requests in flight, buffers
// returned instructions with their PCs, and flushes/restarts on redirect.
`include "isa.svh"
module ifu_pf
  import ifu_pkg::*;
#(
  parameter int              PC_W       = `RV_PC_SIZE,
  parameter int              IR_W       = `RV_IR_SIZE,
  parameter int              OUTSTD     = 2,
  parameter int              IBUF_DEPTH = 4,
  parameter logic [PC_W-1:0] RST_PC     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fch_req_vld,
  input  logic            fch_req_rdy,
  output logic [PC_W-1:0] fch_req_pc,
  input  logic            fch_rsp_vld,
  output logic            fch_rsp_rdy,
  input  logic [IR_W-1:0] fch_rsp_ir,
  output logic            ex_req_vld,
  input  logic            ex_req_rdy,
  output logic [IR_W-1:0] ex_req_ir,
  output logic [PC_W-1:0] ex_req_pc,
  input  logic            redir_vld,
  input  logic [PC_W-1:0] redir_pc
);
  localparam int CW = $clog2(OUTSTD + 1);
  localparam int OW = $clog2(IBUF_DEPTH) + 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(IFU_PC_STEP);

  logic            run_q;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_tgt;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d;
  logic [OW-1:0]   occ;
  logic [SW-1:0]   reserved;
  logic            req_hsk, rsp_hsk, stale, push, pop, ibuf_empty;
  ibuf_entry_t     push_ent, head;

  assign redir_tgt   = redir_pc & ~PC_W'(3);
  // Buffer slots are reserved at issue, so live requests count against capacity.
  assign reserved    = SW'(inflight_q) - SW'(drop_q) + SW'(occ);
  assign fch_req_vld = run_q & ~redir_vld & (inflight_q < CW'(OUTSTD)) &
                       (reserved < SW'(IBUF_DEPTH));
  assign fch_req_pc  = fetch_pc_q;
  assign fch_rsp_rdy = 1'b1;
  assign req_hsk     = fch_req_vld & fch_req_rdy;
  assign rsp_hsk     = fch_rsp_vld;
  assign stale       = (drop_q != '0) | redir_vld;
  assign push        = rsp_hsk & ~stale;
  assign ex_req_vld  = ~ibuf_empty & ~redir_vld;
  assign pop         = ex_req_vld & ex_req_rdy;
  assign ex_req_ir   = ibuf_empty ? '0 : head.ir;
  assign ex_req_pc   = ibuf_empty ? '0 : head.pc;

  always_comb begin
    push_ent.pc = rsp_pc_q;
    push_ent.ir = fch_rsp_ir;
  end

  ifu_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redir_vld),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (ibuf_empty),
    .count_o     (occ)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_hsk) - CW'(rsp_hsk);
    drop_d     = drop_q;
    if (redir_vld) begin
      fetch_pc_d = redir_tgt;
      rsp_pc_d   = redir_tgt;
      drop_d     = inflight_q - CW'(rsp_hsk);
    end else begin
      if (req_hsk) fetch_pc_d = fetch_pc_q + STEP;
      if (push)    rsp_pc_d   = rsp_pc_q + STEP;
      if (rsp_hsk && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RST_PC;
      rsp_pc_q   <= RST_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end
endmodule
